multi_bullet_generator: RTL

MULTI_BULLET_GENERATOR -- requirements
Module: multi_bullet_generator

---
 rtl/multi_bullet_generator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multi_bullet_generator.sv
// Falling-bullet field: LFSR-driven lane spawner feeding a fixed set of slots
// that fall one row per move tick and retire at the bottom, on a hit, or when the game stops.
module multi_bullet_generator #(
  parameter int unsigned NUM_BULLETS    = 4,
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned LANE_X0        = 61,
  parameter int unsigned LANE_PITCH     = 10,
  parameter int unsigned SCREEN_HEIGHT  = 120,
  parameter int unsigned SPAWN_INTERVAL = 25_000_000,
  parameter int unsigned MOVE_INTERVAL  = 5_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [2:0]  BULLET_COLOR   = 3'b011
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     player_collision,
  input  logic [NUM_BULLETS-1:0]   hit,
  input  logic [1:0]               speed_level,
  output logic [8*NUM_BULLETS-1:0] bullet_x,
  output logic [7*NUM_BULLETS-1:0] bullet_y,
  output logic [NUM_BULLETS-1:0]   bullet_active,
  output logic [3*NUM_BULLETS-1:0] bullet_color,
  output logic [3:0]               active_count,
  output logic                     spawn_dropped,
  output logic [15:0]              dodged_count
);

  localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W     = 32;
  localparam logic [6:0]  Y_LAST    = 7'(SCREEN_HEIGHT - 1);
  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_INTERVAL - 1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
  logic [7:0]       x_q [NUM_BULLETS];
  logic [7:0]       x_d [NUM_BULLETS];
  logic [6:0]       y_q [NUM_BULLETS];
  logic [6:0]       y_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic             dropped_q, dropped_d;
  logic [15:0]      dodged_q, dodged_d;

  logic                   run;
  logic                   spawn_attempt;
  logic                   move_tick;
  logic [CNT_W-1:0]       move_period;
  logic [LANE_BITS-1:0]   lane;
  logic [7:0]             spawn_x;
  logic [NUM_BULLETS-1:0] spawn_sel;
  logic                   slot_found;
  logic [3:0]             dodge_num;
  logic [16:0]            dodged_sum;

  // Free-running LFSR and the two run-gated interval counters.
  always_comb begin
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    run           = enable && !player_collision;
    spawn_attempt = run && (spawn_cnt_q == SPAWN_LAST);
    move_period   = CNT_W'(MOVE_INTERVAL) >> speed_level;
    // A count already past a freshly shortened period wraps at once.
    move_tick     = run && (move_cnt_q >= (move_period - CNT_W'(1)));
    spawn_cnt_d   = spawn_cnt_q + CNT_W'(1);
    move_cnt_d    = move_cnt_q + CNT_W'(1);
    if (!run || spawn_attempt) spawn_cnt_d = '0;
    if (!run || move_tick)     move_cnt_d  = '0;
  end

  // Spawn target: lowest slot that was free at the start of the cycle.
  always_comb begin
    lane       = lfsr_q[LANE_BITS-1:0];
    spawn_x    = 8'(LANE_X0 + LANE_PITCH * CNT_W'(lane));
    spawn_sel  = '0;
    slot_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_q[i] && !slot_found) begin
        spawn_sel[i] = spawn_attempt;
        slot_found   = 1'b1;
      end
    end
  end

  // Per-slot next state: hit beats move, move beats spawn, stop clears the field.
  always_comb begin
    active_d  = active_q;
    dodge_num = '0;
    dropped_d = spawn_attempt && !slot_found;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (!run) begin
        active_d[i] = 1'b0;
        y_d[i]      = '0;
      end else if (active_q[i] && hit[i]) begin
        active_d[i] = 1'b0;
        y_d[i]      = '0;
      end else if (active_q[i] && move_tick) begin
        if (y_q[i] < Y_LAST) begin
          y_d[i] = y_q[i] + 7'd1;
        end else begin
          active_d[i] = 1'b0;
          dodge_num   = dodge_num + 4'd1;
        end
      end else if (spawn_sel[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = spawn_x;
        y_d[i]      = '0;
      end
    end
    dodged_sum = {1'b0, dodged_q} + 17'(dodge_num);
    dodged_d   = dodged_sum[16] ? 16'hFFFF : dodged_sum[15:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lfsr_q      <= LFSR_SEED;
      spawn_cnt_q <= '0;
      move_cnt_q  <= '0;
      active_q    <= '0;
      dropped_q   <= 1'b0;
      dodged_q    <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= 8'(LANE_X0);
        y_q[i] <= '0;
      end
    end else begin
      lfsr_q      <= lfsr_d;
      spawn_cnt_q <= spawn_cnt_d;
      move_cnt_q  <= move_cnt_d;
      active_q    <= active_d;
      dropped_q   <= dropped_d;
      dodged_q    <= dodged_d;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  // Output packing, colour and population count.
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bullet_x[8*i +: 8]     = x_q[i];
      bullet_y[7*i +: 7]     = y_q[i];
      bullet_color[3*i +: 3] = active_q[i] ? BULLET_COLOR : 3'b000;
      active_count           = active_count + 4'(active_q[i]);
    end
    bullet_active = active_q;
    spawn_dropped = dropped_q;
    dodged_count  = dodged_q;
  end

endmodule
